// File: rtl/buffered_instruction_decoder_if.sv
`default_nettype none
// ============================================================================
// buffered_instruction_decoder_if : fetch/execute-side bundle of the decoder
// Revision: 1.0
// ============================================================================

interface buffered_instruction_decoder_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      instr;
  logic [PC_W-1:0]  in_pc;

  logic             out_valid;
  logic             out_ready;
  logic [6:0]       op;
  logic [15:0]      off;
  logic [2:0]       dst;
  logic [2:0]       srccon;
  logic             rc;
  logic             wb;
  logic             prpo;
  logic             dec;
  logic             inc;
  logic [7:0]       imbyte;
  logic [3:0]       c;
  logic [2:0]       t;
  logic [2:0]       f;
  logic [4:0]       pswb;
  logic [PC_W-1:0]  out_pc;
  logic             fault;
  logic [LVL_W-1:0] level;

  modport master (
    output flush, in_valid, instr, in_pc, out_ready,
    input  in_ready, out_valid, op, off, dst, srccon, rc, wb, prpo, dec, inc,
           imbyte, c, t, f, pswb, out_pc, fault, level
  );

  modport slave (
    input  flush, in_valid, instr, in_pc, out_ready,
    output in_ready, out_valid, op, off, dst, srccon, rc, wb, prpo, dec, inc,
           imbyte, c, t, f, pswb, out_pc, fault, level
  );
endinterface

`default_nettype wire

// File: rtl/buffered_instruction_decoder.sv
`default_nettype none
// ============================================================================
// buffered_instruction_decoder : FIFO-buffered XM-23 decoder, registered output
// Revision: 1.0
// ============================================================================

module buffered_instruction_decoder #(
  parameter int DEPTH    = 4,
  parameter int PC_W     = 16,
  parameter int SEXT_OFF = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  buffered_instruction_decoder_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [6:0]  op;
    logic [15:0] off;
    logic [2:0]  dst;
    logic [2:0]  srccon;
    logic        rc;
    logic        wb;
    logic        prpo;
    logic        dec;
    logic        inc;
    logic [7:0]  imbyte;
    logic [3:0]  c;
    logic [2:0]  t;
    logic [2:0]  f;
    logic [4:0]  pswb;
    logic        fault;
  } dec_t;

  logic [15:0]     instr_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;

  logic        in_ready;
  logic        push;
  logic        pop;
  logic        illegal;
  logic [15:0] w;

  dec_t            out_d, out_q;
  logic [PC_W-1:0] out_pc_q;
  logic            out_valid_q;

  assign in_ready = (level_q != LVL_W'(DEPTH));
  assign push     = bus.in_valid & in_ready;
  assign pop      = (level_q != '0) & (~out_valid_q | bus.out_ready);
  assign w        = instr_mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push && !bus.flush) begin
      instr_mem_q[wr_ptr_q] <= bus.instr;
      pc_mem_q[wr_ptr_q]    <= bus.in_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Decode of the FIFO head; illegal words collapse to OP 127 with all fields 0.
  always_comb begin
    out_d   = '0;
    illegal = 1'b0;
    case (w[15:13])
      3'b000: begin
        out_d.op  = 7'd0;
        out_d.off = (SEXT_OFF != 0) ? {{2{w[12]}}, w[12:0], 1'b0} : {3'b000, w[12:0]};
      end
      3'b001: begin
        out_d.op  = 7'd1 + {4'b0000, w[12:10]};
        out_d.off = (SEXT_OFF != 0) ? {{5{w[9]}}, w[9:0], 1'b0} : {6'b000000, w[9:0]};
      end
      3'b010: begin
        if (!w[12] && (w[11:10] != 2'b11)) begin
          out_d.op     = 7'd9 + {3'b000, w[11:8]};
          out_d.rc     = w[7];
          out_d.wb     = w[6];
          out_d.srccon = w[5:3];
          out_d.dst    = w[2:0];
        end else if (!w[12]) begin
          case (w[9:7])
            3'b000: begin
              out_d.op     = 7'd21;
              out_d.wb     = w[6];
              out_d.srccon = w[5:3];
              out_d.dst    = w[2:0];
            end
            3'b001: begin
              out_d.op     = 7'd22;
              out_d.srccon = w[5:3];
              out_d.dst    = w[2:0];
            end
            3'b010: begin
              if (w[5]) begin
                illegal = 1'b1;
              end else begin
                out_d.op  = 7'd23 + {5'b00000, w[4:3]};
                out_d.wb  = w[6] & ~w[4];
                out_d.dst = w[2:0];
              end
            end
            3'b011: begin
              out_d.pswb = w[4:0];
              case (w[6:5])
                2'b00:   out_d.op = w[4] ? 7'd28 : 7'd27;
                2'b01:   out_d.op = 7'd29;
                2'b10:   out_d.op = 7'd30;
                default: illegal  = 1'b1;
              endcase
            end
            default: illegal = 1'b1;
          endcase
        end else begin
          case (w[11:10])
            2'b00: begin
              out_d.op = 7'd32;
              out_d.c  = w[9:6];
              out_d.t  = w[5:3];
              out_d.f  = w[2:0];
            end
            2'b01: begin
              out_d.op = 7'd41;
              illegal  = (w[9:0] != 10'd0);
            end
            default: begin
              out_d.op     = w[10] ? 7'd34 : 7'd33;
              out_d.prpo   = w[9];
              out_d.dec    = w[8];
              out_d.inc    = w[7];
              out_d.wb     = w[6];
              out_d.srccon = w[5:3];
              out_d.dst    = w[2:0];
            end
          endcase
        end
      end
      3'b011: begin
        out_d.op     = 7'd35 + {5'b00000, w[12:11]};
        out_d.imbyte = w[10:3];
        out_d.dst    = w[2:0];
      end
      default: begin
        out_d.op     = w[14] ? 7'd40 : 7'd39;
        out_d.off    = (SEXT_OFF != 0) ? {{9{w[13]}}, w[13:7]} : {9'd0, w[13:7]};
        out_d.wb     = w[6];
        out_d.srccon = w[5:3];
        out_d.dst    = w[2:0];
      end
    endcase
    if (illegal) begin
      out_d       = '0;
      out_d.op    = 7'd127;
      out_d.fault = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q       <= '0;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      out_q       <= '0;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (pop) begin
      out_q       <= out_d;
      out_pc_q    <= pc_mem_q[rd_ptr_q];
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.level     = level_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.op        = out_q.op;
  assign bus.off       = out_q.off;
  assign bus.dst       = out_q.dst;
  assign bus.srccon    = out_q.srccon;
  assign bus.rc        = out_q.rc;
  assign bus.wb        = out_q.wb;
  assign bus.prpo      = out_q.prpo;
  assign bus.dec       = out_q.dec;
  assign bus.inc       = out_q.inc;
  assign bus.imbyte    = out_q.imbyte;
  assign bus.c         = out_q.c;
  assign bus.t         = out_q.t;
  assign bus.f         = out_q.f;
  assign bus.pswb      = out_q.pswb;
  assign bus.fault     = out_q.fault;
endmodule

`default_nettype wire
